// File: rtl/hdmi_timing_pkg.sv
// Shared 640x480@60 raster constants, total-size helpers and the TMDS control-bit layout
// used by the timing controller and its alignment pipe.
package hdmi_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // Bit positions of the sync flags inside the encoder i_ctrl pair
   localparam int CTRL_HS = 0;
   localparam int CTRL_VS = 1;

   // Payload carried down the alignment pipe; vs/hs sit at CTRL_VS/CTRL_HS
   typedef struct packed {
      logic de;
      logic vs;
      logic hs;
   } tmds_ctrl_t;

   function automatic int h_total(int active, int fp, int sync, int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int v_total(int active, int fp, int sync, int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that lines the DE/sync controls up with the fetched pixel.
// Reset loads every stage with RST_VAL so the encoders see blanking until real data arrives.
module sync_delay_line #(
   parameter int               WIDTH   = 3,
   parameter int               DEPTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RST_VAL;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing controller: walks the pixel grid, requests active pixels and drives DE/sync
// to the TMDS encoders, delayed so they line up with the pixel source's read latency.
module video_timing_ctrl
   import hdmi_timing_pkg::*;
#(
   parameter int   H_ACTIVE    = DEF_H_ACTIVE,
   parameter int   H_FP        = DEF_H_FP,
   parameter int   H_SYNC      = DEF_H_SYNC,
   parameter int   H_BP        = DEF_H_BP,
   parameter int   V_ACTIVE    = DEF_V_ACTIVE,
   parameter int   V_FP        = DEF_V_FP,
   parameter int   V_SYNC      = DEF_V_SYNC,
   parameter int   V_BP        = DEF_V_BP,
   parameter logic HS_POL      = 1'b0,
   parameter logic VS_POL      = 1'b0,
   parameter int   PIX_LATENCY = 2
) (
   input  logic        i_pixclk,
   input  logic        i_rst,
   input  logic        i_en,
   output logic [11:0] o_x,
   output logic [11:0] o_y,
   output logic        o_req,
   output logic        o_line_start,
   output logic        o_frame_start,
   output logic        o_de,
   output logic [1:0]  o_ctrl
);

   localparam logic [11:0] H_TOTAL_C  = 12'(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
   localparam logic [11:0] V_TOTAL_C  = 12'(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
   localparam logic [11:0] H_ACT_C    = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT_C    = 12'(V_ACTIVE);
   localparam logic [11:0] HS_START_C = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END_C   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VS_START_C = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END_C   = 12'(V_ACTIVE + V_FP + V_SYNC);

   localparam tmds_ctrl_t BLANK_C = '{de: 1'b0, vs: ~VS_POL, hs: ~HS_POL};

   // h_q/v_q hold the position that the next enabled edge will present on o_x/o_y
   logic [11:0] h_q, h_d;
   logic [11:0] v_q, v_d;
   logic [11:0] x_q, x_d;
   logic [11:0] y_q, y_d;
   logic        req_q, req_d;
   logic        line_start_q, line_start_d;
   logic        frame_start_q, frame_start_d;
   tmds_ctrl_t  pix_ctrl_q, pix_ctrl_d;
   tmds_ctrl_t  dly_ctrl;

   logic in_active;
   logic hs_on;
   logic vs_on;

   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (!i_en) begin
         h_d = '0;
         v_d = '0;
      end else if (h_q == H_TOTAL_C - 12'd1) begin
         h_d = '0;
         v_d = (v_q == V_TOTAL_C - 12'd1) ? 12'd0 : v_q + 12'd1;
      end else begin
         h_d = h_q + 12'd1;
      end
   end

   assign in_active = (h_q < H_ACT_C) && (v_q < V_ACT_C);
   assign hs_on     = (h_q >= HS_START_C) && (h_q < HS_END_C);
   assign vs_on     = (v_q >= VS_START_C) && (v_q < VS_END_C);

   // Disabled cycles present a blank (0,0) so a restart can never resume mid-line
   always_comb begin
      x_d           = '0;
      y_d           = '0;
      req_d         = 1'b0;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      pix_ctrl_d    = BLANK_C;
      if (i_en) begin
         x_d           = h_q;
         y_d           = v_q;
         req_d         = in_active;
         line_start_d  = (h_q == 12'd0);
         frame_start_d = (h_q == 12'd0) && (v_q == 12'd0);
         pix_ctrl_d    = '{de: in_active,
                           vs: vs_on ? VS_POL : ~VS_POL,
                           hs: hs_on ? HS_POL : ~HS_POL};
      end
   end

   always_ff @(posedge i_pixclk) begin
      if (i_rst) begin
         h_q           <= '0;
         v_q           <= '0;
         x_q           <= '0;
         y_q           <= '0;
         req_q         <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         pix_ctrl_q    <= BLANK_C;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         x_q           <= x_d;
         y_q           <= y_d;
         req_q         <= req_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         pix_ctrl_q    <= pix_ctrl_d;
      end
   end

   // Zero latency means the pixel source answers in the request cycle: no pipe at all
   if (PIX_LATENCY == 0) begin : g_no_delay
      assign dly_ctrl = pix_ctrl_q;
   end else begin : g_delay
      sync_delay_line #(
         .WIDTH   ($bits(tmds_ctrl_t)),
         .DEPTH   (PIX_LATENCY),
         .RST_VAL (BLANK_C)
      ) u_align (
         .clk_i (i_pixclk),
         .rst_i (i_rst),
         .d_i   (pix_ctrl_q),
         .q_o   (dly_ctrl)
      );
   end

   assign o_x               = x_q;
   assign o_y               = y_q;
   assign o_req             = req_q;
   assign o_line_start      = line_start_q;
   assign o_frame_start     = frame_start_q;
   assign o_de              = dly_ctrl.de;
   assign o_ctrl[CTRL_VS]   = dly_ctrl.vs;
   assign o_ctrl[CTRL_HS]   = dly_ctrl.hs;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl: three default-timing instances (latency 0/2/3) checked every cycle
// against a queued reference model, plus a reduced-raster instance for whole-frame behaviour.
module tb_video_timing_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;

   always #5 clk = ~clk;

   logic [11:0] x2, y2, x0, y0, x3, y3, xS, yS;
   logic        req2, ls2, fs2, de2, req0, ls0, fs0, de0, req3, ls3, fs3, de3;
   logic        reqS, lsS, fsS, deS;
   logic [1:0]  ctrl2, ctrl0, ctrl3, ctrlS;

   video_timing_ctrl dut2 (
      .i_pixclk(clk), .i_rst(rst), .i_en(en), .o_x(x2), .o_y(y2), .o_req(req2),
      .o_line_start(ls2), .o_frame_start(fs2), .o_de(de2), .o_ctrl(ctrl2));

   video_timing_ctrl #(.PIX_LATENCY(0)) dut0 (
      .i_pixclk(clk), .i_rst(rst), .i_en(en), .o_x(x0), .o_y(y0), .o_req(req0),
      .o_line_start(ls0), .o_frame_start(fs0), .o_de(de0), .o_ctrl(ctrl0));

   video_timing_ctrl #(.PIX_LATENCY(3)) dut3 (
      .i_pixclk(clk), .i_rst(rst), .i_en(en), .o_x(x3), .o_y(y3), .o_req(req3),
      .o_line_start(ls3), .o_frame_start(fs3), .o_de(de3), .o_ctrl(ctrl3));

   // 16 x 9 raster, active-high syncs, one cycle of latency
   video_timing_ctrl #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LATENCY(1)
   ) dutS (
      .i_pixclk(clk), .i_rst(rst), .i_en(en), .o_x(xS), .o_y(yS), .o_req(reqS),
      .o_line_start(lsS), .o_frame_start(fsS), .o_de(deS), .o_ctrl(ctrlS));

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic        req;
      logic        ls;
      logic        fs;
   } raw_t;

   typedef struct packed {
      raw_t       r;
      logic [2:0] d0;
      logic [2:0] d2;
      logic [2:0] d3;
   } exp_t;

   localparam logic [2:0] BLANK3 = 3'b011;

   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q[$];
   logic [2:0]  hist[$];
   logic [11:0] mh = 12'd0;
   logic [11:0] mv = 12'd0;
   exp_t        mon_e;

   // Reference model for the default 800x525 raster; hist holds the undelayed {de,vs,hs} per edge
   task automatic tick();
      exp_t       e;
      raw_t       r;
      logic       vs, hs;
      r = '0;
      if (rst) begin
         mh = 12'd0;
         mv = 12'd0;
         hist.delete();
         repeat (4) hist.push_back(BLANK3);
      end else if (!en) begin
         mh = 12'd0;
         mv = 12'd0;
         hist.push_back(BLANK3);
      end else begin
         r.x   = mh;
         r.y   = mv;
         r.req = (mh < 12'd640) && (mv < 12'd480);
         r.ls  = (mh == 12'd0);
         r.fs  = (mh == 12'd0) && (mv == 12'd0);
         hs    = !((mh >= 12'd656) && (mh < 12'd752));
         vs    = !((mv >= 12'd490) && (mv < 12'd492));
         hist.push_back({r.req, vs, hs});
         if (mh == 12'd799) begin
            mh = 12'd0;
            mv = (mv == 12'd524) ? 12'd0 : mv + 12'd1;
         end else begin
            mh = mh + 12'd1;
         end
      end
      while (hist.size() > 8) void'(hist.pop_front());
      e.r  = r;
      e.d0 = hist[hist.size()-1];
      e.d2 = hist[hist.size()-3];
      e.d3 = hist[hist.size()-4];
      exp_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         if ({x2, y2, req2, ls2, fs2, de2, ctrl2} !== {mon_e.r, mon_e.d2}) begin
            errors++;
            $display("FAIL sb_lat2 t=%0t got %h want %h", $time,
                     {x2, y2, req2, ls2, fs2, de2, ctrl2}, {mon_e.r, mon_e.d2});
         end
         checks++;
         if ({x0, y0, req0, ls0, fs0, de0, ctrl0} !== {mon_e.r, mon_e.d0}) begin
            errors++;
            $display("FAIL sb_lat0 t=%0t got %h want %h", $time,
                     {x0, y0, req0, ls0, fs0, de0, ctrl0}, {mon_e.r, mon_e.d0});
         end
         checks++;
         if ({x3, y3, req3, ls3, fs3, de3, ctrl3} !== {mon_e.r, mon_e.d3}) begin
            errors++;
            $display("FAIL sb_lat3 t=%0t got %h want %h", $time,
                     {x3, y3, req3, ls3, fs3, de3, ctrl3}, {mon_e.r, mon_e.d3});
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b0;
      repeat (3) tick();
      checks++;
      if ({x2, y2, req2, ls2, fs2, de2, ctrl2} !== {24'd0, 4'b0000, 2'b11}) begin
         errors++;
         $display("FAIL reset_state got %h want %h", {x2, y2, req2, ls2, fs2, de2, ctrl2},
                  {24'd0, 4'b0000, 2'b11});
      end
      checks++;
      if ({deS, ctrlS} !== 3'b000) begin
         errors++;
         $display("FAIL reset_active_high_pol got %b want 000", {deS, ctrlS});
      end
      rst = 1'b0;
      en  = 1'b1;
      tick();
      checks++;
      if ({x2, y2, req2, ls2, fs2} !== {24'd0, 3'b111}) begin
         errors++;
         $display("FAIL first_enable got %h want %h", {x2, y2, req2, ls2, fs2}, {24'd0, 3'b111});
      end
   endtask

   task automatic test_active_edge();
      for (int i = 0; i < 1000; i++) begin
         if (x2 == 12'd639) break;
         tick();
      end
      checks++;
      if ({x2, y2, req2} !== {12'd639, 12'd0, 1'b1}) begin
         errors++;
         $display("FAIL last_active got x=%0d y=%0d req=%b want x=639 y=0 req=1", x2, y2, req2);
      end
      tick();
      checks++;
      if ({x2, req2} !== {12'd640, 1'b0}) begin
         errors++;
         $display("FAIL first_blank got x=%0d req=%b want x=640 req=0", x2, req2);
      end
   endtask

   task automatic test_hsync();
      int first_x = -1;
      int last_x  = -1;
      int cnt     = 0;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (ctrl0[0] === 1'b0) begin
            if (first_x < 0) first_x = int'(x0);
            last_x = int'(x0);
            cnt++;
         end
         if (x0 == 12'd799) break;
      end
      checks++;
      if (first_x != 656 || last_x != 751 || cnt != 96) begin
         errors++;
         $display("FAIL hsync_window got first=%0d last=%0d width=%0d want 656 751 96",
                  first_x, last_x, cnt);
      end
      tick();
      checks++;
      if ({x0, y0, ls0, fs0, ctrl0[0]} !== {12'd0, 12'd1, 3'b101}) begin
         errors++;
         $display("FAIL line_wrap got x=%0d y=%0d ls=%b fs=%b hs=%b want 0 1 1 0 1",
                  x0, y0, ls0, fs0, ctrl0[0]);
      end
   endtask

   task automatic test_latency();
      int r0 = -1, d2r = -1, d3r = -1, h0 = -1, h3 = -1, w3 = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      en  = 1'b1;
      for (int n = 0; n < 900; n++) begin
         tick();
         if (r0  < 0 && req0 === 1'b1)     r0  = n;
         if (d2r < 0 && de2 === 1'b1)      d2r = n;
         if (d3r < 0 && de3 === 1'b1)      d3r = n;
         if (h0  < 0 && ctrl0[0] === 1'b0) h0  = n;
         if (h3  < 0 && ctrl3[0] === 1'b0) h3  = n;
         if (n < 800 && de3 === 1'b1)      w3++;
      end
      checks++;
      if (r0 != 0 || d3r - r0 != 3) begin
         errors++;
         $display("FAIL de_lat3_rise got req@%0d de@%0d want req@0 de@3", r0, d3r);
      end
      checks++;
      if (d2r - r0 != 2) begin
         errors++;
         $display("FAIL de_lat2_rise got offset %0d want 2", d2r - r0);
      end
      checks++;
      if (w3 != 640) begin
         errors++;
         $display("FAIL de_lat3_width got %0d want 640", w3);
      end
      checks++;
      if (h0 != 656 || h3 - h0 != 3) begin
         errors++;
         $display("FAIL ctrl_lat3_shift got hs0@%0d hs3@%0d want 656 659", h0, h3);
      end
   endtask

   task automatic test_mid_reset();
      logic found = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      en  = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (x2 == 12'd300 && y2 == 12'd2) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found || de3 !== 1'b1) begin
         errors++;
         $display("FAIL reach_300_2 got found=%b de3=%b want 1 1", found, de3);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({x2, y2, req2, fs2, de2, ctrl2, de3, ctrl3} !== {24'd0, 4'b0011, 3'b011}) begin
         errors++;
         $display("FAIL mid_reset got %h want %h", {x2, y2, req2, fs2, de2, ctrl2, de3, ctrl3},
                  {24'd0, 4'b0011, 3'b011});
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({x2, y2, req2, fs2} !== {24'd0, 2'b11}) begin
         errors++;
         $display("FAIL after_mid_reset got %h want %h", {x2, y2, req2, fs2}, {24'd0, 2'b11});
      end
   endtask

   task automatic test_enable_drop();
      int bad = 0;
      for (int i = 0; i < 200; i++) begin
         if (x2 == 12'd100) break;
         tick();
      end
      checks++;
      if (x2 !== 12'd100) begin
         errors++;
         $display("FAIL reach_x100 got x=%0d want 100", x2);
      end
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (req2 !== 1'b0 || ls2 !== 1'b0 || fs2 !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL disabled_quiet got %0d active cycles want 0", bad);
      end
      checks++;
      if ({x2, y2, de2, ctrl2} !== {24'd0, 3'b011}) begin
         errors++;
         $display("FAIL disabled_blank got %h want %h", {x2, y2, de2, ctrl2}, {24'd0, 3'b011});
      end
      en = 1'b1;
      tick();
      checks++;
      if ({x2, y2, req2, fs2} !== {24'd0, 2'b11}) begin
         errors++;
         $display("FAIL reenable got %h want %h", {x2, y2, req2, fs2}, {24'd0, 2'b11});
      end
   endtask

   task automatic test_frame();
      int          fs_at[$];
      int          mism = 0, vs_cnt = 0, req_cnt = 0, ls_cnt = 0;
      logic        pv = 1'b0;
      logic [11:0] px = 12'd0, py = 12'd0;
      logic [2:0]  want;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      en  = 1'b1;
      for (int n = 0; n < 452; n++) begin
         tick();
         if (pv)
            want = {(px < 12'd8) && (py < 12'd4), (py >= 12'd5) && (py < 12'd7),
                    (px >= 12'd10) && (px < 12'd13)};
         else
            want = 3'b000;
         if ({deS, ctrlS} !== want) mism++;
         if (ctrlS[1] === 1'b1) vs_cnt++;
         if (reqS === 1'b1)     req_cnt++;
         if (lsS === 1'b1)      ls_cnt++;
         if (fsS === 1'b1)      fs_at.push_back(n);
         pv = 1'b1;
         px = xS;
         py = yS;
      end
      checks++;
      if (mism != 0) begin
         errors++;
         $display("FAIL small_ctrl_align got %0d bad cycles want 0", mism);
      end
      checks++;
      if (vs_cnt != 96) begin
         errors++;
         $display("FAIL small_vsync_cycles got %0d want 96", vs_cnt);
      end
      checks++;
      if (req_cnt != 108 || ls_cnt != 29) begin
         errors++;
         $display("FAIL small_req_lines got req=%0d ls=%0d want 108 29", req_cnt, ls_cnt);
      end
      checks++;
      if (fs_at.size() != 4) begin
         errors++;
         $display("FAIL frame_count got %0d want 4", fs_at.size());
      end else begin
         checks++;
         if (fs_at[0] != 0 || fs_at[1] - fs_at[0] != 144 || fs_at[3] - fs_at[2] != 144) begin
            errors++;
            $display("FAIL frame_period got %0d %0d %0d %0d want 0 144 288 432",
                     fs_at[0], fs_at[1], fs_at[2], fs_at[3]);
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog t=%0t bench did not complete", $time);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_active_edge();
      test_hsync();
      test_latency();
      test_mid_reset();
      test_enable_drop();
      test_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
